// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD CMD-line constants and receiver state type
package sd_pkg;
    localparam logic [6:0] CRC7_POLY    = 7'h09;
    localparam int         SD_RESP_BITS = 48;
    localparam int         SD_NCR_MAX   = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECV,
        DONE
    } rx_state_t;
endpackage

// File: rtl/crc7_serial.sv
// rtl/crc7_serial.sv - bit-serial CRC7 (x^7+x^3+1), shared by CMD transmit and receive
module crc7_serial
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);
    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb = r_crc[6] ^ bit_in;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
        end
    end

    assign crc = r_crc;
endmodule

// File: rtl/sd_cmd_rx.sv
// rtl/sd_cmd_rx.sv - SD CMD-line response receiver with CRC7, frame and timeout checks
module sd_cmd_rx
    import sd_pkg::*;
#(
    parameter int RESP_BITS = SD_RESP_BITS,
    parameter int NCR_MAX   = SD_NCR_MAX,
    parameter int CNT_W     = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        skip_crc,
    input  logic        bit_en,
    input  logic        cmd_in,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        crc_err,
    output logic        frame_err,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic [6:0]  resp_crc
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] CRC_BITS = CNT_W'(RESP_BITS - 8);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(NCR_MAX - 1);

    rx_state_t r_state, w_next;

    // The start bit is always 0, so only token bits [46:1] are kept.
    logic [RESP_BITS-3:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     r_to_cnt;
    logic                 r_skip;
    logic                 r_timeout;
    logic                 r_crc_err;
    logic                 r_frame_err;
    logic [5:0]           r_index;
    logic [31:0]          r_arg;
    logic [6:0]           r_crc;

    logic                 w_arm;
    logic                 w_crc_en;
    logic                 w_got_start;
    logic                 w_to_inc;
    logic                 w_shift_en;
    logic                 w_finish;
    logic                 w_to_hit;
    logic [6:0]           w_crc;
    logic [RESP_BITS-2:0] w_tok;

    assign w_tok = {r_shift, cmd_in};

    crc7_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_arm),
        .en     (w_crc_en),
        .bit_in (cmd_in),
        .crc    (w_crc)
    );

    always_comb begin
        w_next      = r_state;
        w_arm       = 1'b0;
        w_crc_en    = 1'b0;
        w_got_start = 1'b0;
        w_to_inc    = 1'b0;
        w_shift_en  = 1'b0;
        w_finish    = 1'b0;
        w_to_hit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = WAIT_START;
                    w_arm  = 1'b1;
                end
            end
            WAIT_START: begin
                if (bit_en) begin
                    if (!cmd_in) begin
                        w_next      = RECV;
                        w_crc_en    = 1'b1;
                        w_got_start = 1'b1;
                    end else if (r_to_cnt == TO_LAST) begin
                        w_next   = DONE;
                        w_to_hit = 1'b1;
                    end else begin
                        w_to_inc = 1'b1;
                    end
                end
            end
            RECV: begin
                if (bit_en) begin
                    w_crc_en   = (r_bit_cnt < CRC_BITS);
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_next   = DONE;
                        w_finish = 1'b1;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_skip      <= 1'b0;
            r_timeout   <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_index     <= '0;
            r_arg       <= '0;
            r_crc       <= '0;
        end else begin
            r_state <= w_next;
            if (w_arm) begin
                r_shift     <= '0;
                r_bit_cnt   <= '0;
                r_to_cnt    <= '0;
                r_skip      <= skip_crc;
                r_timeout   <= 1'b0;
                r_crc_err   <= 1'b0;
                r_frame_err <= 1'b0;
                r_index     <= '0;
                r_arg       <= '0;
                r_crc       <= '0;
            end
            if (w_got_start) begin
                r_bit_cnt <= CNT_W'(1);
            end
            if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_shift_en) begin
                r_shift   <= w_tok[RESP_BITS-3:0];
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            // Results are taken straight from the final strobe so they line up with done.
            if (w_finish) begin
                r_index     <= w_tok[RESP_BITS-3 -: 6];
                r_arg       <= w_tok[RESP_BITS-9 -: 32];
                r_crc       <= w_tok[7:1];
                r_crc_err   <= !r_skip && (w_tok[7:1] != w_crc);
                r_frame_err <= w_tok[RESP_BITS-2] || !w_tok[0];
            end
        end
    end

    assign busy       = (r_state == WAIT_START) || (r_state == RECV);
    assign done       = (r_state == DONE);
    assign timeout    = r_timeout;
    assign crc_err    = r_crc_err;
    assign frame_err  = r_frame_err;
    assign resp_index = r_index;
    assign resp_arg   = r_arg;
    assign resp_crc   = r_crc;
endmodule

// File: tb/tb_sd_cmd_rx.sv
// tb/tb_sd_cmd_rx.sv - self-checking bench for sd_cmd_rx against a token-level model
module tb_sd_cmd_rx;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        skip_crc;
    logic        bit_en;
    logic        cmd_in;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        crc_err;
    logic        frame_err;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic [6:0]  resp_crc;

    always #5 clk = ~clk;

    sd_cmd_rx dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .skip_crc   (skip_crc),
        .bit_en     (bit_en),
        .cmd_in     (cmd_in),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .crc_err    (crc_err),
        .frame_err  (frame_err),
        .resp_index (resp_index),
        .resp_arg   (resp_arg),
        .resp_crc   (resp_crc)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_print = 0;
    int done_cnt = 0;
    logic chk_en = 1'b0;

    // CRC7 by polynomial long division of m(x)*x^7 by 0x89.
    function automatic logic [6:0] crc7_div(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    int          m_phase = 0;
    int          m_idle = 0;
    int          m_n = 0;
    logic [47:0] m_tok = '0;
    logic        m_skip = 1'b0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_to = 1'b0, m_ce = 1'b0, m_fe = 1'b0;
    logic [5:0]  m_idx = '0;
    logic [31:0] m_arg = '0;
    logic [6:0]  m_crc = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_to = 0; m_ce = 0; m_fe = 0;
            m_idx = 0; m_arg = 0; m_crc = 0; m_n = 0; m_idle = 0;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1; m_to = 0; m_ce = 0; m_fe = 0;
                m_idx = 0; m_arg = 0; m_crc = 0;
                m_skip = skip_crc; m_n = 0; m_idle = 0;
            end
        end else if (bit_en) begin
            if (m_n == 0) begin
                if (!cmd_in) begin
                    m_tok = '0;
                    m_n = 1;
                end else begin
                    m_idle++;
                    if (m_idle == 64) begin
                        m_to = 1;
                        m_phase = 2;
                    end
                end
            end else begin
                m_tok = {m_tok[46:0], cmd_in};
                m_n++;
                if (m_n == 48) begin
                    m_idx = m_tok[45:40];
                    m_arg = m_tok[39:8];
                    m_crc = m_tok[7:1];
                    m_ce  = !m_skip && (crc7_div(m_tok[47:8]) != m_tok[7:1]);
                    m_fe  = m_tok[46] || !m_tok[0];
                    m_phase = 2;
                end
            end
        end
        m_busy = (m_phase == 1);
        m_done = (m_phase == 2);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [49:0] act, exp;
            act = {busy, done, timeout, crc_err, frame_err, resp_index, resp_arg, resp_crc};
            exp = {m_busy, m_done, m_to, m_ce, m_fe, m_idx, m_arg, m_crc};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                if (n_print < 20) begin
                    n_print++;
                    $display("FAIL cycle_model t=%0t got b/d/to/ce/fe/idx/arg/crc=%b%b%b%b%b/%h/%h/%h want %b%b%b%b%b/%h/%h/%h",
                             $time, busy, done, timeout, crc_err, frame_err, resp_index, resp_arg, resp_crc,
                             m_busy, m_done, m_to, m_ce, m_fe, m_idx, m_arg, m_crc);
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b, input logic st);
        bit_en = 1'b1; cmd_in = b; start = st;
        tick();
        bit_en = 1'b0; cmd_in = 1'b1; start = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic skip, input logic coincide);
        start = 1'b1; skip_crc = skip;
        if (coincide) begin bit_en = 1'b1; cmd_in = 1'b0; end
        tick();
        start = 1'b0; skip_crc = ~skip; bit_en = 1'b0; cmd_in = 1'b1;
    endtask

    task automatic send(input logic [47:0] tok, input logic skip, input int idle_n,
                        input int start_at, input int reset_at, input logic coincide);
        do_start(skip, coincide);
        repeat (idle_n) strobe(1'b1, 1'b0);
        for (int i = 0; i < 48; i++) begin
            if (i == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                return;
            end
            strobe(tok[47 - i], i == start_at);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; skip_crc = 1'b0; bit_en = 1'b0; cmd_in = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_arg", 64'(resp_arg), 64'd0);
        reset = 1'b0;
        tick();

        check("model_crc_cmd17", 64'(crc7_div(40'h1100000900)), 64'h33);
        check("model_crc_r7", 64'(crc7_div(40'h08000001AA)), 64'h09);

        send(48'h11_00000900_67, 1'b0, 5, -1, -1, 1'b0);
        check("cmd17_index", 64'(resp_index), 64'h11);
        check("cmd17_arg", 64'(resp_arg), 64'h900);
        check("cmd17_crc", 64'(resp_crc), 64'h33);
        check("cmd17_flags", 64'({timeout, crc_err, frame_err}), 64'd0);
        check("cmd17_done_cnt", 64'(done_cnt), 64'd1);

        send(48'h08_000001AA_13, 1'b0, 2, -1, -1, 1'b1);
        check("r7_index", 64'(resp_index), 64'h08);
        check("r7_arg", 64'(resp_arg), 64'h1AA);
        check("r7_crc", 64'(resp_crc), 64'h09);
        check("r7_crc_err", 64'(crc_err), 64'd0);

        send(48'h11_00000901_67, 1'b0, 3, -1, -1, 1'b0);
        check("flip_crc_err", 64'(crc_err), 64'd1);
        check("flip_frame_err", 64'(frame_err), 64'd0);
        check("flip_arg", 64'(resp_arg), 64'h901);

        send(48'h3F_00FF8000_FF, 1'b1, 1, -1, -1, 1'b0);
        check("r3_skip_crc_err", 64'(crc_err), 64'd0);
        check("r3_crc", 64'(resp_crc), 64'h7F);
        send(48'h3F_00FF8000_FF, 1'b0, 1, -1, -1, 1'b0);
        check("r3_noskip_crc_err", 64'(crc_err), 64'd1);
        check("r3_done_cnt", 64'(done_cnt), 64'd5);

        do_start(1'b0, 1'b0);
        repeat (64) strobe(1'b1, 1'b0);
        tick();
        check("to_timeout", 64'(timeout), 64'd1);
        check("to_arg", 64'(resp_arg), 64'd0);
        check("to_errs", 64'({crc_err, frame_err}), 64'd0);
        check("to_done_cnt", 64'(done_cnt), 64'd6);

        send(48'h11_00000900_67, 1'b0, 63, -1, -1, 1'b0);
        check("edge63_timeout", 64'(timeout), 64'd0);
        check("edge63_arg", 64'(resp_arg), 64'h900);

        send(48'h11_00000900_67, 1'b0, 2, 10, -1, 1'b0);
        check("midstart_arg", 64'(resp_arg), 64'h900);
        check("midstart_done_cnt", 64'(done_cnt), 64'd8);

        send(48'h08_000001AA_13, 1'b0, 2, -1, 20, 1'b0);
        check("rst20_busy", 64'(busy), 64'd0);
        repeat (30) tick();
        check("rst20_done_cnt", 64'(done_cnt), 64'd8);
        check("rst20_index", 64'(resp_index), 64'd0);

        send(48'h11_00000900_66, 1'b0, 2, -1, -1, 1'b0);
        check("endbit_frame_err", 64'(frame_err), 64'd1);
        check("endbit_crc_err", 64'(crc_err), 64'd0);
        do_start(1'b0, 1'b0);
        check("restart_frame_clr", 64'(frame_err), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        repeat (64) strobe(1'b1, 1'b0);
        tick();
        check("final_done_cnt", 64'(done_cnt), 64'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sd_cmd_rx.md
Name: sd_cmd_rx

Overview:
Receive end of the SD CMD line. It captures one 48-bit response token (R1/R1b/R3/R6/R7) bit-serially after the host has sent a command. It computes CRC7 on the fly (G(x)=x^7+x^3+1) and checks start, transmission and end bits. It presents the index, argument, CRC and error flags to the host-controller FSM; it is the checking counterpart of the command-side CRC7 generator.

Parameters:
RESP_BITS, 48, total token length in bits (start bit through end bit)
NCR_MAX, 64, number of sample strobes to wait for the start bit before declaring timeout
CNT_W, 7, width of bit and timeout counters (must hold max(RESP_BITS, NCR_MAX))

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: arm receiver (sampled only in IDLE)
skip_crc  input  1  latched at start; 1 = ignore CRC result (R3, CRC field all ones)
bit_en  input  1  sample strobe, one clk wide, at the SD-clock rising edge
cmd_in  input  1  CMD line level (already synchronised)
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse: response complete or timed out
timeout  output  1  no start bit within NCR_MAX strobes
crc_err  output  1  received CRC7 != computed CRC7 (forced 0 if skip_crc)
frame_err  output  1  transmission bit != 0 or end bit != 1
resp_index  output  6  bits [45:40] of token
resp_arg  output  32  bits [39:8] of token
resp_crc  output  7  bits [7:1] of token as received

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs are 0; shift register, CRC register and counters are cleared. Reset mid-reception aborts with no done pulse.
- The line is sampled only on clk edges where bit_en=1. Nothing advances without bit_en.
- IDLE: start=1 -> WAIT_START. This clears timeout/crc_err/frame_err/resp_* and the CRC register, sets busy, and latches skip_crc. A bit_en coincident with start is ignored; the first sample is on the next strobe.
- WAIT_START, on bit_en:
  - cmd_in=0 -> RECV, bit count=1, CRC updated with bit 0.
  - cmd_in=1 -> timeout counter increments.
  - On the strobe that would make the count equal NCR_MAX -> DONE with timeout=1.
- RECV, on bit_en: shift cmd_in into the shift register MSB-first and increment the bit count.
  - Bits 0..39 (start, transmission, index, argument) feed the CRC.
  - Bits 40..46 are not fed.
  - The strobe that samples bit 47 (count RESP_BITS-1) -> DONE.
- Serial CRC update: fb = crc[6] ^ bit; crc <= {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
- DONE (one cycle):
  - done=1, busy=0.
  - resp_index, resp_arg and resp_crc are loaded from the shift register.
  - crc_err = !skip_crc && (resp_crc != crc).
  - frame_err = (bit46 of token, the transmission bit, != 0) || (bit47 sample != 1).
  - Then -> IDLE.
- Latency: done asserts exactly one clk after the bit_en that samples the end bit (or the final timeout strobe).
- Result outputs and flags hold until the next accepted start.
- start while busy is ignored; it has no effect on the current capture.
- On timeout, resp_* stay 0 and crc_err/frame_err stay 0.
- A start bit on the very strobe that exhausts the timeout is accepted: the start bit takes priority.

Decomposition:
- Shared package sd_pkg:
  - CRC7_POLY = 7'h09
  - SD_RESP_BITS = 48
  - SD_NCR_MAX = 64
  - rx state enum {IDLE, WAIT_START, RECV, DONE}
- One sub-module: crc7_serial (clk, reset, clear, en, bit_in, crc[6:0]). It is a bit-serial CRC7 reusable by the command transmitter.

Test Plan:
- CMD17 response 0x11_00000900_67 driven MSB-first after 5 idle-high strobes -> done; resp_index=0x11, resp_arg=0x00000900, resp_crc=0x33, crc_err=0, frame_err=0, timeout=0.
- R7 token 0x08_000001AA_13 -> resp_index=0x08, resp_arg=0x000001AA, resp_crc=0x09, crc_err=0.
- Same CMD17 token with arg bit 0 flipped (0x00000901) -> crc_err=1, frame_err=0, resp_arg=0x00000901.
- R3 token 0x3F_00FF8000_FF with skip_crc=1 -> crc_err=0, resp_crc=0x7F; repeat with skip_crc=0 -> crc_err=1.
- cmd_in held 1 for 64 strobes after start -> done on the clk after strobe 64, timeout=1, resp_arg=0; start pulse mid-reception ignored, and reset asserted at bit 20 -> busy=0 next cycle, no done.
- End bit driven 0 on the CMD17 token -> frame_err=1, crc_err=0; a second start clears frame_err in the following cycle.
